// File: rtl/pc_sequencer_if.sv
// Fetch-control bundle between the hazard/branch sources and the pc sequencer.
// master drives requests and redirects; slave (the sequencer) returns pc and hold vector.
interface pc_sequencer_if;
  logic        stall_req_id;
  logic        stall_req_ex;
  logic        stall_req_mem;
  logic        inst_ready;
  logic        branch_flag;
  logic [31:0] branch_addr;
  logic        flush;
  logic [31:0] flush_pc;
  logic [31:0] pc;
  logic        rom_en;
  logic [4:0]  stall;
  logic        branch_pending;

  modport master (
    output stall_req_id, stall_req_ex, stall_req_mem, inst_ready,
           branch_flag, branch_addr, flush, flush_pc,
    input  pc, rom_en, stall, branch_pending
  );

  modport slave (
    input  stall_req_id, stall_req_ex, stall_req_mem, inst_ready,
           branch_flag, branch_addr, flush, flush_pc,
    output pc, rom_en, stall, branch_pending
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter and pipeline hold-vector controller for the five-stage core.
// Honours the branch delay slot by parking a taken target while the delay-slot fetch waits.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input logic          clk,
  input logic          rst,
  pc_sequencer_if.slave bus
);
  typedef enum logic [1:0] {S_RESET, S_RUN, S_PEND} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pend_tgt;
  logic        rom_en;
  logic        branch_pending;
  logic [4:0]  stall;
  logic        take;

  // Only the highest-priority hold source applies.
  always_comb begin
    stall = 5'b00000;
    if (state == S_RESET)                      stall = 5'b00001;
    else if (bus.flush)                        stall = 5'b00000;
    else if (bus.stall_req_mem)                stall = 5'b01111;
    else if (bus.stall_req_ex)                 stall = 5'b00111;
    else if (bus.stall_req_id)                 stall = 5'b00011;
    else if (rom_en && !bus.inst_ready)        stall = 5'b00001;
  end

  // The branch leaves ID only when if_id is not held; a second branch while parked is dropped.
  assign take = bus.branch_flag && !stall[1] && (state == S_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_RESET;
      pc             <= RESET_PC;
      pend_tgt       <= 32'h0;
      rom_en         <= 1'b0;
      branch_pending <= 1'b0;
    end else begin
      case (state)
        S_RESET: begin
          state  <= S_RUN;
          rom_en <= 1'b1;
        end
        default: begin
          if (bus.flush) begin
            pc             <= bus.flush_pc;
            pend_tgt       <= 32'h0;
            state          <= S_RUN;
            branch_pending <= 1'b0;
          end else if (stall[0]) begin
            if (take) begin
              pend_tgt       <= bus.branch_addr;
              state          <= S_PEND;
              branch_pending <= 1'b1;
            end
          end else if (state == S_PEND) begin
            pc             <= pend_tgt;
            pend_tgt       <= 32'h0;
            state          <= S_RUN;
            branch_pending <= 1'b0;
          end else if (take) begin
            pc <= bus.branch_addr;
          end else begin
            pc <= pc + 32'd4;
          end
        end
      endcase
    end
  end

  assign bus.pc             = pc;
  assign bus.rom_en         = rom_en;
  assign bus.stall          = stall;
  assign bus.branch_pending = branch_pending;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plus randomized check of pc_sequencer against a hold-depth reference model.
module tb_pc_sequencer;
  localparam logic [31:0] RPC = 32'hBFC0_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pc_sequencer_if bus();
  pc_sequencer #(.RESET_PC(RPC)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  // stimulus
  bit          r_rst, r_id, r_ex, r_mem, r_ir, r_bf, r_fl;
  logic [31:0] r_ba, r_fpc;

  // reference model
  bit          m_boot;   // still in the post-reset cycle
  bit          m_rom;
  bit          m_pend;
  logic [31:0] m_pc, m_tgt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h", tag, obs, exp);
    end
  endtask

  // Number of pipeline registers held, counted from pc downstream.
  function automatic int hold_depth();
    if (m_boot)                 return 1;
    if (r_fl)                   return 0;
    if (r_mem)                  return 4;
    if (r_ex)                   return 3;
    if (r_id)                   return 2;
    if (m_rom && !r_ir)         return 1;
    return 0;
  endfunction

  function automatic logic [4:0] exp_stall();
    return 5'((1 << hold_depth()) - 1);
  endfunction

  task automatic model_step();
    int  d;
    bit  take;
    d    = hold_depth();
    take = r_bf && (d < 2) && !m_pend && !m_boot;
    if (r_rst) begin
      m_boot = 1; m_rom = 0; m_pend = 0; m_pc = RPC; m_tgt = 0;
    end else if (m_boot) begin
      m_boot = 0; m_rom = 1;
    end else if (r_fl) begin
      m_pc = r_fpc; m_pend = 0;
    end else if (d >= 1) begin
      if (take) begin m_pend = 1; m_tgt = r_ba; end
    end else if (m_pend) begin
      m_pc = m_tgt; m_pend = 0;
    end else if (take) begin
      m_pc = r_ba;
    end else begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic drive();
    rst               = r_rst;
    bus.stall_req_id  = r_id;
    bus.stall_req_ex  = r_ex;
    bus.stall_req_mem = r_mem;
    bus.inst_ready    = r_ir;
    bus.branch_flag   = r_bf;
    bus.branch_addr   = r_ba;
    bus.flush         = r_fl;
    bus.flush_pc      = r_fpc;
  endtask

  // One clock: drive, check at the falling edge, advance model, step past rising edge.
  task automatic cyc();
    drive();
    @(negedge clk);
    chk("pc",      bus.pc, m_pc);
    chk("rom_en",  32'(bus.rom_en), 32'(m_rom));
    chk("pending", 32'(bus.branch_pending), 32'(m_pend));
    chk("stall",   32'(bus.stall), 32'(exp_stall()));
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    r_rst = 0; r_id = 0; r_ex = 0; r_mem = 0; r_ir = 1; r_bf = 0; r_fl = 0;
    r_ba = 32'h0; r_fpc = 32'h0;
  endtask

  initial begin
    m_boot = 1; m_rom = 0; m_pend = 0; m_pc = RPC; m_tgt = 0;
    quiet();
    r_rst = 1;
    cyc(); cyc();
    chk("rst_pc", bus.pc, RPC);
    chk("rst_rom", 32'(bus.rom_en), 32'd0);
    chk("rst_stall", 32'(bus.stall), 32'b00001);

    // reset release and sequential fetch
    r_rst = 0;
    cyc();
    chk("boot_rom", 32'(bus.rom_en), 32'd1);
    chk("boot_pc", bus.pc, 32'hBFC0_0000);
    cyc(); chk("seq1", bus.pc, 32'hBFC0_0004);
    cyc(); chk("seq2", bus.pc, 32'hBFC0_0008);
    cyc(); cyc();
    chk("at10", bus.pc, 32'hBFC0_0010);

    // taken branch, no stalls
    r_bf = 1; r_ba = 32'hBFC0_0100; cyc(); r_bf = 0;
    chk("br_tgt", bus.pc, 32'hBFC0_0100);

    // branch during IF wait
    r_fl = 1; r_fpc = 32'hBFC0_0010; cyc(); r_fl = 0;
    r_bf = 1; r_ir = 0; cyc(); r_bf = 0;
    chk("wait_pend", 32'(bus.branch_pending), 32'd1);
    cyc(); cyc();
    chk("wait_hold", bus.pc, 32'hBFC0_0010);
    r_ir = 1; cyc();
    chk("wait_tgt", bus.pc, 32'hBFC0_0100);
    chk("wait_clr", 32'(bus.branch_pending), 32'd0);

    // ID stall drops the branch, re-presented afterwards
    r_id = 1; r_bf = 1; r_ba = 32'hBFC0_0200; drive(); #1;
    chk("id_stall", 32'(bus.stall), 32'b00011);
    cyc();
    chk("id_hold", bus.pc, 32'hBFC0_0100);
    r_id = 0; cyc(); r_bf = 0;
    chk("id_retry", bus.pc, 32'hBFC0_0200);

    // mem+id stall, then flush overriding a parked target
    r_mem = 1; r_id = 1; drive(); #1;
    chk("mem_stall", 32'(bus.stall), 32'b01111);
    cyc();
    r_mem = 0; r_id = 0; r_ir = 0; r_bf = 1; r_ba = 32'hBFC0_0300; cyc(); r_bf = 0;
    chk("pend_set", 32'(bus.branch_pending), 32'd1);
    r_fl = 1; r_fpc = 32'hBFC0_0380; drive(); #1;
    chk("fl_stall", 32'(bus.stall), 32'b00000);
    cyc(); r_fl = 0; r_ir = 1;
    chk("fl_pc", bus.pc, 32'hBFC0_0380);
    chk("fl_pend", 32'(bus.branch_pending), 32'd0);

    // 32-bit wrap
    r_fl = 1; r_fpc = 32'hFFFF_FFFC; cyc(); r_fl = 0;
    cyc();
    chk("wrap", bus.pc, 32'h0000_0000);

    // reset while a target is parked
    r_ir = 0; r_bf = 1; r_ba = 32'h1234_5678; cyc(); r_bf = 0;
    r_rst = 1; cyc();
    chk("rst_mid_pc", bus.pc, RPC);
    chk("rst_mid_pend", 32'(bus.branch_pending), 32'd0);
    r_rst = 0; r_ir = 1; cyc();

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      r_rst = ($urandom_range(0, 99) == 0);
      r_fl  = ($urandom_range(0, 19) == 0);
      r_mem = ($urandom_range(0, 9) == 0);
      r_ex  = ($urandom_range(0, 7) == 0);
      r_id  = ($urandom_range(0, 5) == 0);
      r_ir  = ($urandom_range(0, 3) != 0);
      r_bf  = ($urandom_range(0, 3) == 0);
      r_ba  = {$urandom()} & 32'hFFFF_FFFC;
      r_fpc = {$urandom()} & 32'hFFFF_FFFC;
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
